// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, constants and queue entry type for the fetch unit
package fetch_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ILEN     = 32;
  localparam int PC_INC   = 4;

  // One decoded-side queue slot: where the word came from and the word itself.
  // pc is carried at the widest supported width; narrower XLEN builds zero-extend.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [ILEN-1:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - redirect, icache and decode handshake bundle for fetch_queue
import fetch_pkg::*;

interface fetch_queue_if #(
  parameter int XLEN = XLEN_DEF
) ();

  // Redirect / stall from branch resolution
  logic            REDIRECT_V;
  logic [XLEN-1:0] REDIRECT_PC;
  logic            HOLD;

  // Instruction cache request / response
  logic            IC_READY;
  logic            IC_REQ_V;
  logic [XLEN-1:0] IC_PC;
  logic            IC_RSP_V;
  logic [ILEN-1:0] IC_RSP_INSTR;

  // Decode side
  logic            DE_READY;
  logic            DE_V;
  logic [XLEN-1:0] DE_PC;
  logic [XLEN-1:0] DE_NPC;
  logic [ILEN-1:0] DE_IR;

  // The fetch unit drives requests and the decode head
  modport master (
    input  REDIRECT_V, REDIRECT_PC, HOLD,
    input  IC_READY, IC_RSP_V, IC_RSP_INSTR,
    input  DE_READY,
    output IC_REQ_V, IC_PC,
    output DE_V, DE_PC, DE_NPC, DE_IR
  );

  // The surrounding pipeline / cache model
  modport slave (
    output REDIRECT_V, REDIRECT_PC, HOLD,
    output IC_READY, IC_RSP_V, IC_RSP_INSTR,
    output DE_READY,
    input  IC_REQ_V, IC_PC,
    input  DE_V, DE_PC, DE_NPC, DE_IR
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry instruction queue with flush and registered head
import fetch_pkg::*;

module fetch_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  fetch_entry_t  din_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  // Storage is deliberately not reset; only pointers and count are.
  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // Pointer and occupancy next-state; flush wins over push/pop, pointers wrap at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rst_i || flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk_i) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Entry write; a flushed cycle must not leave a stale entry behind a reset pointer
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i && !rst_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC generation, icache request gating and decode queue
import fetch_pkg::*;

module fetch_queue #(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic           CLK,
  input logic           RESET,
  fetch_queue_if.master bus
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] pc_q,     pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;

  logic            req_v;
  logic            accept;
  logic            push;
  logic            pop;
  logic            de_v;
  logic [XLEN-1:0] de_pc;
  logic [CW:0]     occupancy;
  logic [CW-1:0]   count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Slots already spoken for: queued entries plus the response still on its way
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};

  assign req_v  = !RESET && !bus.HOLD && !bus.REDIRECT_V && (occupancy < DEPTH_W);
  assign accept = req_v && bus.IC_READY;

  // inflight_q is cleared by redirect/reset, so a squashed or stray response is dropped here
  assign push = bus.IC_RSP_V && inflight_q && !bus.REDIRECT_V && !RESET;
  assign de_v = (count != '0);
  assign pop  = de_v && bus.DE_READY && !bus.REDIRECT_V && !RESET;

  assign push_entry = '{pc: XLEN_DEF'(req_pc_q), instr: bus.IC_RSP_INSTR};

  // Fetch PC, request-PC capture and inflight tracking; reset beats redirect beats a normal accept
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    if (RESET) begin
      pc_d = RESET_PC;
    end else if (bus.REDIRECT_V) begin
      pc_d = bus.REDIRECT_PC;
    end else begin
      inflight_d = accept;
      if (accept) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + XLEN'(PC_INC);
      end
    end
  end

  // Control state registers
  always_ff @(posedge CLK) begin
    pc_q       <= pc_d;
    req_pc_q   <= req_pc_d;
    inflight_q <= inflight_d;
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .flush_i (bus.REDIRECT_V),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign de_pc        = head.pc[XLEN-1:0];
  assign bus.IC_REQ_V = req_v;
  assign bus.IC_PC    = pc_q;
  assign bus.DE_V     = de_v;
  assign bus.DE_PC    = de_pc;
  assign bus.DE_NPC   = de_pc + XLEN'(PC_INC);
  assign bus.DE_IR    = head.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed vector bench for fetch_queue and its FIFO
import fetch_pkg::*;

module tb_fetch_queue;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  fetch_queue_if #(.XLEN(64)) bus ();

  fetch_queue #(
    .XLEN     (64),
    .DEPTH    (4),
    .RESET_PC (64'h1000)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  logic         f_flush = 1'b0;
  logic         f_push  = 1'b0;
  logic         f_pop   = 1'b0;
  fetch_entry_t f_din   = '0;
  fetch_entry_t f_head;
  logic [2:0]   f_count;

  fetch_fifo #(.DEPTH(4)) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .flush_i (f_flush),
    .push_i  (f_push),
    .pop_i   (f_pop),
    .din_i   (f_din),
    .head_o  (f_head),
    .count_o (f_count)
  );

  typedef struct {
    logic        rst;
    logic        rdr;
    logic [63:0] rpc;
    logic        hold;
    logic        rdy;
    logic        der;
    logic        frsp;
    logic        exp_req;
    logic [63:0] exp_pc;
    logic        exp_dv;
    logic [63:0] exp_dpc;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        acc_prev;
  logic [63:0] acc_pc_prev;

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_0000;
  endfunction

  function automatic vec_t mk(input logic rst, input logic rdr, input logic [63:0] rpc,
                              input logic hold, input logic der, input logic frsp,
                              input logic req, input logic [63:0] pc,
                              input logic dv, input logic [63:0] dpc);
    vec_t v;
    v.rst = rst; v.rdr = rdr; v.rpc = rpc; v.hold = hold; v.rdy = 1'b1;
    v.der = der; v.frsp = frsp; v.exp_req = req; v.exp_pc = pc;
    v.exp_dv = dv; v.exp_dpc = dpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    // rst rdr rpc hold der frsp | req pc dv dpc
    vecs.push_back(mk(1,0,64'h0,0,1,0, 0,64'h1000,0,64'h0));             // 0 reset state
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h1000,0,64'h0));             // 1 first request
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h1004,0,64'h0));
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h1008,1,64'h1000));          // 3 N+2 latency
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h100C,1,64'h1004));
    vecs.push_back(mk(1,0,64'h0,0,0,0, 0,64'h1010,1,64'h1008));          // 5 reset mid-stream
    vecs.push_back(mk(0,0,64'h0,0,0,0, 1,64'h1000,0,64'h0));             // 6 decode stalled
    vecs.push_back(mk(0,0,64'h0,0,0,0, 1,64'h1004,0,64'h0));
    vecs.push_back(mk(0,0,64'h0,0,0,0, 1,64'h1008,1,64'h1000));
    vecs.push_back(mk(0,0,64'h0,0,0,0, 1,64'h100C,1,64'h1000));
    vecs.push_back(mk(0,0,64'h0,0,0,0, 0,64'h1010,1,64'h1000));          // 10 4th in flight
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0,0,64'h0,0,0,0, 0,64'h1010,1,64'h1000));        // 11-15 full, held
    vecs.push_back(mk(0,0,64'h0,0,1,0, 0,64'h1010,1,64'h1000));          // 16 drain
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h1010,1,64'h1004));
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h1014,1,64'h1008));
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h1018,1,64'h100C));
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h101C,1,64'h1010));
    vecs.push_back(mk(0,0,64'h0,0,0,0, 1,64'h1020,1,64'h1014));          // 21
    vecs.push_back(mk(0,1,64'h2000,0,0,0, 0,64'h1024,1,64'h1014));       // 22 redirect, 3 queued + 1 in flight
    vecs.push_back(mk(0,0,64'h0,0,1,1, 1,64'h2000,0,64'h0));             // 23 flushed, stray rsp
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h2004,0,64'h0));
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h2008,1,64'h2000));          // 25
    vecs.push_back(mk(0,0,64'h0,1,1,0, 0,64'h200C,1,64'h2004));          // 26 hold
    vecs.push_back(mk(0,0,64'h0,1,1,0, 0,64'h200C,1,64'h2008));
    vecs.push_back(mk(0,0,64'h0,1,1,0, 0,64'h200C,0,64'h0));
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h200C,0,64'h0));             // 29 resume
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h2010,0,64'h0));
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h2014,1,64'h200C));
    vecs.push_back(mk(0,0,64'h0,0,0,0, 1,64'h2018,1,64'h2010));          // 32 fill
    vecs.push_back(mk(0,0,64'h0,0,0,0, 1,64'h201C,1,64'h2010));
    vecs.push_back(mk(0,0,64'h0,0,0,0, 0,64'h2020,1,64'h2010));
    vecs.push_back(mk(1,0,64'h0,0,0,1, 0,64'h2020,1,64'h2010));          // 35 reset while full
    vecs.push_back(mk(0,0,64'h0,0,1,1, 1,64'h1000,0,64'h0));             // 36 late rsp
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h1004,0,64'h0));
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h1008,1,64'h1000));
    vecs.push_back(mk(0,1,64'hFFFF_FFFF_FFFF_FFFC,0,1,0, 0,64'h100C,1,64'h1004)); // 39
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'hFFFF_FFFF_FFFF_FFFC,0,64'h0));
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h0,0,64'h0));                // 41 PC wrap
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h4,1,64'hFFFF_FFFF_FFFF_FFFC));
    vecs.push_back(mk(0,0,64'h0,0,1,0, 1,64'h8,1,64'h0));

    bus.REDIRECT_V   = 1'b0;
    bus.REDIRECT_PC  = '0;
    bus.HOLD         = 1'b0;
    bus.IC_READY     = 1'b1;
    bus.IC_RSP_V     = 1'b0;
    bus.IC_RSP_INSTR = '0;
    bus.DE_READY     = 1'b1;
    RESET            = 1'b1;
    acc_prev         = 1'b0;
    acc_pc_prev      = '0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      RESET            = vecs[i].rst;
      bus.REDIRECT_V   = vecs[i].rdr;
      bus.REDIRECT_PC  = vecs[i].rpc;
      bus.HOLD         = vecs[i].hold;
      bus.IC_READY     = vecs[i].rdy;
      bus.DE_READY     = vecs[i].der;
      bus.IC_RSP_V     = acc_prev || vecs[i].frsp;
      bus.IC_RSP_INSTR = acc_prev ? instr_of(acc_pc_prev) : 32'hDEAD_BEEF;
      #1;
      chk($sformatf("v%0d ic_req_v", i), 64'(bus.IC_REQ_V), 64'(vecs[i].exp_req));
      chk($sformatf("v%0d ic_pc", i), bus.IC_PC, vecs[i].exp_pc);
      chk($sformatf("v%0d de_v", i), 64'(bus.DE_V), 64'(vecs[i].exp_dv));
      if (vecs[i].exp_dv) begin
        chk($sformatf("v%0d de_pc", i), bus.DE_PC, vecs[i].exp_dpc);
        chk($sformatf("v%0d de_npc", i), bus.DE_NPC, vecs[i].exp_dpc + 64'd4);
        chk($sformatf("v%0d de_ir", i), 64'(bus.DE_IR), 64'(instr_of(vecs[i].exp_dpc)));
      end
      acc_prev    = bus.IC_REQ_V && bus.IC_READY;
      acc_pc_prev = bus.IC_PC;
    end

    // Quiet the top, then exercise push+pop at full occupancy on the FIFO directly
    @(negedge CLK);
    bus.IC_RSP_V = 1'b0;
    bus.HOLD     = 1'b1;
    f_flush      = 1'b1;
    @(negedge CLK);
    f_flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      f_push   = 1'b1;
      f_din.pc = 64'(16 * (k + 1));
      f_din.instr = 32'(k);
      @(negedge CLK);
    end
    f_push = 1'b0;
    chk("fifo full count", 64'(f_count), 64'd4);
    chk("fifo full head", f_head.pc, 64'h10);
    f_push   = 1'b1;
    f_pop    = 1'b1;
    f_din.pc = 64'h50;
    @(negedge CLK);
    chk("fifo pushpop1 count", 64'(f_count), 64'd4);
    chk("fifo pushpop1 head", f_head.pc, 64'h20);
    f_din.pc = 64'h60;
    @(negedge CLK);
    chk("fifo pushpop2 count", 64'(f_count), 64'd4);
    f_push = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fifo drain%0d head", k), f_head.pc, 64'h30 + 64'(16 * k));
      @(negedge CLK);
    end
    f_pop = 1'b0;
    chk("fifo empty count", 64'(f_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 64, PC/address width.
REQ-002 Parameter DEPTH, default 4, instruction queue entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 0, PC loaded on reset.
REQ-004 CLK  in  1  clock; all state updates on its rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 REDIRECT_V  in  1  taken-branch or jump redirect request.
REQ-007 REDIRECT_PC  in  XLEN  redirect target.
REQ-008 HOLD  in  1  branch-resolution stall; no new fetch requests while high.
REQ-009 IC_READY  in  1  instruction cache accepts a request this cycle.
REQ-010 IC_REQ_V  out  1  fetch request valid.
REQ-011 IC_PC  out  XLEN  fetch address, equal to the internal fetch PC.
REQ-012 IC_RSP_V  in  1  response valid, exactly 1 cycle after an accepted request.
REQ-013 IC_RSP_INSTR  in  32  instruction word returned.
REQ-014 DE_READY  in  1  decode accepts the head entry (low = dependency stall).
REQ-015 DE_V  out  1  head entry valid.
REQ-016 DE_PC  out  XLEN  PC of the head entry.
REQ-017 DE_NPC  out  XLEN  DE_PC + 4.
REQ-018 DE_IR  out  32  instruction of the head entry.

Function
REQ-019 A request is accepted when IC_REQ_V && IC_READY; the fetch PC then advances by 4, modulo 2^XLEN.
REQ-020 IC_REQ_V = !RESET && !HOLD && !REDIRECT_V && (count + inflight < DEPTH); inflight is 1 if a request was accepted in the previous cycle and has not been squashed.
REQ-021 A response with IC_RSP_V high and not squashed is enqueued as {PC of the accepted request, IC_RSP_INSTR}.
REQ-022 A dequeue occurs when DE_V && DE_READY; DE_V = (count != 0); DE_PC, DE_NPC and DE_IR reflect the head entry combinationally from registered storage.
REQ-023 Fetch-to-decode latency: request accepted in cycle N -> entry is visible on DE_* in cycle N+2 (no bypass).
REQ-024 Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
REQ-025 Pointers wrap modulo DEPTH; count ranges 0..DEPTH and never overflows, as guaranteed by REQ-020.
REQ-026 IC_RSP_V arriving with no outstanding request is ignored.
REQ-027 On REDIRECT_V the following happen in the same edge: the queue is flushed (count = 0, pointers = 0), the in-flight response is marked squashed, and the fetch PC is loaded with REDIRECT_PC. A request to REDIRECT_PC may issue in the next cycle.
REQ-028 REDIRECT_V has priority over a simultaneous dequeue, enqueue, HOLD or accepted request; none of those take effect in that cycle.
REQ-029 While HOLD is high, the queue continues to drain and an in-flight response is still enqueued; the fetch PC is frozen.
REQ-030 While DE_READY is low, the head entry and DE_* are held stable.

Reset
REQ-031 On RESET: fetch PC = RESET_PC; count = 0; pointers = 0; inflight = 0; DE_V = 0; IC_REQ_V = 0.
REQ-032 Queue data storage is not reset; DE_PC, DE_NPC and DE_IR are don't-care while DE_V = 0.
REQ-033 RESET asserted mid-operation discards the queue and the in-flight response; a response arriving in the cycle after reset is ignored.

Structure
REQ-034 Package fetch_pkg holds: XLEN default, ILEN = 32, PC increment 4, and the queue entry struct {pc, instr}.
REQ-035 One sub-module, fetch_fifo: a parametrised DEPTH x entry FIFO with push, pop, flush, count, and head outputs.
REQ-036 The control logic (PC, inflight/squash tracking, request gating) resides in fetch_queue.

Verification
REQ-037 Reset, RESET_PC = 0x1000, IC_READY = 1, DE_READY = 1 -> IC_PC sequence 0x1000, 0x1004, 0x1008; the first DE_V is 2 cycles after the first request, with DE_PC = 0x1000 and DE_NPC = 0x1004.
REQ-038 DE_READY = 0 for 10 cycles, DEPTH = 4 -> exactly 4 entries are queued, IC_REQ_V drops while the 4th response is in flight, and DE_* stays at 0x1000 throughout.
REQ-039 REDIRECT_V with REDIRECT_PC = 0x2000 while 3 entries are queued and 1 request is in flight -> DE_V = 0 in the next cycle, the stale response is dropped, and the next DE_PC = 0x2000.
REQ-040 HOLD high for 3 cycles with the queue draining -> IC_PC frozen, the queue empties, and fetching resumes at the frozen PC after HOLD falls.
REQ-041 RESET asserted while the queue is full and a response is in flight -> the next cycle shows DE_V = 0 and IC_PC = RESET_PC, and the late IC_RSP_V is ignored.
REQ-042 Fetch PC starting at 0xFFFF_FFFF_FFFF_FFFC -> the next IC_PC is 0x0; simultaneous enqueue/dequeue at count = DEPTH keeps the count at DEPTH.
